// File: rtl/bram_stream_reader.sv
// ============================================================================
// Module      : bram_stream_reader
// Description : Reads len_i words from a synchronous BRAM starting at
//               base_addr_i and emits them as a valid/ready stream through a
//               2-entry skid FIFO. Define BRAM_READER_LAST_EN to drive m_last_o.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_stream_reader #(
    parameter int RAM_WIDTH     = 8,
    parameter int RAM_ADDR_BITS = 10
) (
    input  logic                     clk_i,
    input  logic                     arstn_i,
    input  logic                     start_i,
    input  logic [RAM_ADDR_BITS-1:0] base_addr_i,
    input  logic [RAM_ADDR_BITS:0]   len_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     bram_en_o,
    output logic                     bram_we_o,
    output logic [RAM_ADDR_BITS-1:0] bram_addr_o,
    input  logic [RAM_WIDTH-1:0]     bram_rdata_i,
    output logic [RAM_WIDTH-1:0]     m_data_o,
    output logic                     m_valid_o,
    input  logic                     m_ready_i,
    output logic                     m_last_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [RAM_ADDR_BITS-1:0] c_addr_one = 1;
    localparam logic [RAM_ADDR_BITS:0]   c_cnt_one  = 1;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [RAM_ADDR_BITS-1:0] r_addr;
    logic [RAM_ADDR_BITS:0]   r_issue_left;
    logic [RAM_ADDR_BITS:0]   r_beat_left;
    logic                     r_inflight;
    logic [RAM_WIDTH-1:0]     r_fifo [2];
    logic                     r_wptr;
    logic                     r_rptr;
    logic [1:0]               r_count;
    logic                     r_done;

    logic                     w_pop;
    logic                     w_issue;
    logic                     w_start;
    logic                     w_start_zero;
    logic                     w_last_pop;
    logic [2:0]               w_level;

    assign w_pop      = (r_count != 2'd0) && m_ready_i;
    assign w_last_pop = w_pop && (r_beat_left == c_cnt_one);
    // Words already buffered plus the one whose data is still on its way back.
    assign w_level    = {1'b0, r_count} + {2'b00, r_inflight};

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_issue      = 1'b0;
        w_start      = 1'b0;
        w_start_zero = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    if (len_i != '0) begin
                        w_start     = 1'b1;
                        w_state_nxt = ST_READ;
                    end else begin
                        w_start_zero = 1'b1;
                    end
                end
            end
            ST_READ: begin
                // A beat leaving this cycle frees one slot for a new request.
                w_issue = (w_level < (3'd2 + {2'b00, w_pop}));
                if (w_issue && (r_issue_left == c_cnt_one)) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_last_pop) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_addr       <= '0;
            r_issue_left <= '0;
            r_beat_left  <= '0;
            r_inflight   <= 1'b0;
            r_fifo[0]    <= '0;
            r_fifo[1]    <= '0;
            r_wptr       <= 1'b0;
            r_rptr       <= 1'b0;
            r_count      <= 2'd0;
            r_done       <= 1'b0;
        end else begin
            r_done     <= w_start_zero || w_last_pop;
            r_inflight <= w_issue;

            if (w_start) begin
                r_addr       <= base_addr_i;
                r_issue_left <= len_i;
                r_beat_left  <= len_i;
            end else begin
                if (w_issue) begin
                    r_addr       <= r_addr + c_addr_one;
                    r_issue_left <= r_issue_left - c_cnt_one;
                end
                if (w_pop) begin
                    r_beat_left <= r_beat_left - c_cnt_one;
                end
            end

            if (r_inflight) begin
                r_fifo[r_wptr] <= bram_rdata_i;
                r_wptr         <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end

            case ({r_inflight, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign busy_o      = (r_state != ST_IDLE);
    assign done_o      = r_done;
    assign bram_en_o   = w_issue;
    assign bram_we_o   = 1'b0;
    assign bram_addr_o = r_addr;
    assign m_data_o    = r_fifo[r_rptr];
    assign m_valid_o   = (r_count != 2'd0);

`ifdef BRAM_READER_LAST_EN
    assign m_last_o = m_valid_o && (r_beat_left == c_cnt_one);
`else
    assign m_last_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bram_stream_reader.sv
// ============================================================================
// Module      : tb_bram_stream_reader
// Description : Scoreboard bench for bram_stream_reader with a BRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bram_stream_reader;

    localparam int W  = 8;
    localparam int AB = 10;
`ifdef BRAM_READER_LAST_EN
    localparam bit LAST_EN = 1'b1;
`else
    localparam bit LAST_EN = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    logic          clk_i       = 1'b0;
    logic          arstn_i     = 1'b0;
    logic          start_i     = 1'b0;
    logic          m_ready_i   = 1'b0;
    logic [AB-1:0] base_addr_i = '0;
    logic [AB:0]   len_i       = '0;
    logic          busy_o, done_o, bram_en_o, bram_we_o, m_valid_o, m_last_o;
    logic [AB-1:0] bram_addr_o;
    logic [W-1:0]  bram_rdata_i = '0;
    logic [W-1:0]  m_data_o;

    logic [W-1:0]  mem [1<<AB];
    beat_t         exp_q [$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    bit rand_ready = 1'b0;
    bit ready_fix  = 1'b1;

    // Monitor-owned bookkeeping
    logic [AB-1:0] exp_addr = '0;
    int en_cnt = 0, pop_cnt = 0, en_total = 0;
    int beats_seen = 0, done_seen = 0;
    int start_cyc = 0, first_valid_cyc = -1, last_hs_cyc = 0;
    bit hs_since_start = 1'b0;
    bit prev_stall = 1'b0;
    logic [W-1:0] prev_data = '0;

    bram_stream_reader #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB)) dut (
        .clk_i        (clk_i),
        .arstn_i      (arstn_i),
        .start_i      (start_i),
        .base_addr_i  (base_addr_i),
        .len_i        (len_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .bram_en_o    (bram_en_o),
        .bram_we_o    (bram_we_o),
        .bram_addr_o  (bram_addr_o),
        .bram_rdata_i (bram_rdata_i),
        .m_data_o     (m_data_o),
        .m_valid_o    (m_valid_o),
        .m_ready_i    (m_ready_i),
        .m_last_o     (m_last_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < (1 << AB); i++) mem[i] = i[W-1:0];
    end

    always @(posedge clk_i) begin
        if (bram_en_o) bram_rdata_i <= mem[bram_addr_o];
    end

    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            m_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : ready_fix;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    always @(negedge clk_i) begin
        beat_t e;
        if (!arstn_i) begin
            en_cnt     = 0;
            pop_cnt    = 0;
            prev_stall = 1'b0;
        end else begin
            if (start_i && !busy_o) begin
                exp_addr        = base_addr_i;
                start_cyc       = cyc + 1;
                first_valid_cyc = -1;
                hs_since_start  = 1'b0;
            end
            if (bram_en_o) begin
                chk("bram_addr", 32'(bram_addr_o), 32'(exp_addr));
                chk("bram_we", 32'(bram_we_o), 32'd0);
                exp_addr = exp_addr + 1'b1;
                en_cnt++;
                en_total++;
            end
            if (prev_stall) begin
                chk("stall_valid", 32'(m_valid_o), 32'd1);
                chk("stall_data", 32'(m_data_o), 32'(prev_data));
            end
            if (!m_valid_o) chk("last_without_valid", 32'(m_last_o), 32'd0);
            if (m_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (m_valid_o && exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_valid actual_data=0x%0h required=no_beat", m_data_o);
            end else if (m_valid_o && m_ready_i) begin
                e = exp_q.pop_front();
                chk("beat_data", 32'(m_data_o), 32'(e.data));
                chk("beat_last", 32'(m_last_o), 32'(e.last));
            end
            if (m_valid_o && m_ready_i) begin
                pop_cnt++;
                beats_seen++;
                last_hs_cyc    = cyc;
                hs_since_start = 1'b1;
            end
            if (bram_en_o) chk("outstanding_le2", 32'(en_cnt - pop_cnt <= 2), 32'd1);
            if (done_o) begin
                done_seen++;
                chk("busy_at_done", 32'(busy_o), 32'd0);
                if (hs_since_start) chk("done_timing", 32'(cyc), 32'(last_hs_cyc + 1));
            end
            prev_stall = m_valid_o && !m_ready_i;
            prev_data  = m_data_o;
        end
    end

    task automatic push_beat(input logic [W-1:0] d, input logic l);
        beat_t e;
        e.data = d;
        e.last = l & LAST_EN;
        exp_q.push_back(e);
    endtask

    task automatic do_start(input logic [AB-1:0] b, input logic [AB:0] n);
        @(posedge clk_i);
        #1;
        start_i     = 1'b1;
        base_addr_i = b;
        len_i       = n;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int target, input string name);
        int k;
        k = 0;
        while (done_seen < target && k < 300) begin
            @(posedge clk_i);
            k++;
        end
        if (done_seen < target) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual_done=%0d required_done=%0d", name, done_seen, target);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_busy"},  32'(busy_o),      32'd0);
        chk({name, "_done"},  32'(done_o),      32'd0);
        chk({name, "_en"},    32'(bram_en_o),   32'd0);
        chk({name, "_valid"}, 32'(m_valid_o),   32'd0);
        chk({name, "_last"},  32'(m_last_o),    32'd0);
        chk({name, "_addr"},  32'(bram_addr_o), 32'd0);
        chk({name, "_data"},  32'(m_data_o),    32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int b0, d0, e0, k;
        #12;
        chk_reset_outputs("reset");
        @(posedge clk_i);
        #1;
        arstn_i = 1'b1;
        idle(2);

        // Basic transfer, full-rate sink
        b0 = beats_seen; d0 = done_seen;
        for (int i = 0; i < 4; i++) push_beat(8'h10 + 8'(i), i == 3);
        do_start(10'h010, 11'd4);
        wait_done(d0 + 1, "basic");
        idle(3);
        chk("basic_beats", 32'(beats_seen - b0), 32'd4);
        chk("basic_done_pulses", 32'(done_seen - d0), 32'd1);
        chk("basic_latency", 32'(first_valid_cyc - start_cyc), 32'd2);
        chk("basic_back_to_back", 32'(last_hs_cyc - first_valid_cyc), 32'd3);

        // Address wrap at top of memory
        b0 = beats_seen; d0 = done_seen;
        push_beat(8'hFE, 1'b0); push_beat(8'hFF, 1'b0);
        push_beat(8'h00, 1'b0); push_beat(8'h01, 1'b1);
        do_start(10'h3FE, 11'd4);
        wait_done(d0 + 1, "wrap");
        idle(2);
        chk("wrap_beats", 32'(beats_seen - b0), 32'd4);

        // Random backpressure
        b0 = beats_seen; d0 = done_seen;
        rand_ready = 1'b1;
        for (int i = 0; i < 16; i++) push_beat(8'h40 + 8'(i), i == 15);
        do_start(10'h040, 11'd16);
        wait_done(d0 + 1, "backpressure");
        rand_ready = 1'b0;
        idle(2);
        chk("bp_beats", 32'(beats_seen - b0), 32'd16);

        // Zero-length request
        b0 = beats_seen; d0 = done_seen; e0 = en_total;
        do_start(10'h080, 11'd0);
        chk("zero_done", 32'(done_o), 32'd1);
        chk("zero_busy", 32'(busy_o), 32'd0);
        chk("zero_valid", 32'(m_valid_o), 32'd0);
        idle(3);
        chk("zero_done_pulses", 32'(done_seen - d0), 32'd1);
        chk("zero_no_reads", 32'(en_total - e0), 32'd0);
        chk("zero_no_beats", 32'(beats_seen - b0), 32'd0);

        // Start while busy is ignored
        b0 = beats_seen; d0 = done_seen;
        for (int i = 0; i < 4; i++) push_beat(8'h20 + 8'(i), i == 3);
        do_start(10'h020, 11'd4);
        do_start(10'h100, 11'd5);
        wait_done(d0 + 1, "busy_start");
        idle(4);
        chk("busy_start_beats", 32'(beats_seen - b0), 32'd4);
        chk("busy_start_done_pulses", 32'(done_seen - d0), 32'd1);

        // Reset in the middle of an 8-beat transfer
        b0 = beats_seen; d0 = done_seen;
        for (int i = 0; i < 8; i++) push_beat(8'h30 + 8'(i), i == 7);
        do_start(10'h030, 11'd8);
        k = 0;
        while (beats_seen - b0 < 3 && k < 100) begin
            @(posedge clk_i);
            k++;
        end
        chk("midreset_reached_3", 32'(beats_seen - b0), 32'd3);
        #2;
        arstn_i = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        exp_q.delete();
        repeat (2) @(posedge clk_i);
        #1;
        arstn_i = 1'b1;
        idle(4);
        chk("midreset_beats", 32'(beats_seen - b0), 32'd3);
        chk("midreset_no_done", 32'(done_seen - d0), 32'd0);
        b0 = beats_seen; d0 = done_seen;
        push_beat(8'h00, 1'b0); push_beat(8'h01, 1'b1);
        do_start(10'h000, 11'd2);
        wait_done(d0 + 1, "after_reset");
        idle(3);
        chk("after_reset_beats", 32'(beats_seen - b0), 32'd2);

        // Last-beat marker on a 3-beat transfer
        b0 = beats_seen; d0 = done_seen;
        push_beat(8'h55, 1'b0); push_beat(8'h56, 1'b0); push_beat(8'h57, 1'b1);
        do_start(10'h055, 11'd3);
        wait_done(d0 + 1, "last");
        idle(3);
        chk("last_beats", 32'(beats_seen - b0), 32'd3);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
